// File: rtl/lfsr_randomizer.sv
// lfsr_randomizer
//   Draws bounded random numbers (0..MAX_VALUE) from a free-running Galois LFSR
//   using rejection sampling. After MAX_TRIES rejected candidates, the last
//   candidate is folded back into range so that every request completes.
//
// Ports
//   i_Clk         sole clock, rising edge
//   i_Reset_n     asynchronous active-low reset
//   i_Req         request one number; sampled in IDLE only
//   i_Seed_Load   load i_Seed (or SEED when i_Seed is zero) instead of stepping
//   i_Seed        seed value
//   o_Random_Num  last delivered number, held until the next delivery
//   o_Valid       one-cycle pulse when o_Random_Num has been updated
//   o_Busy        high while a draw is in progress
//
// Configuration macro
//   LFSR_RANDOMIZER_NO_REPEAT_EN  when defined, never deliver the same value
//                                 twice in a row
module lfsr_randomizer #(
    parameter int unsigned      WIDTH     = 16,
    parameter logic [WIDTH-1:0] TAPS      = 16'hB400,
    parameter logic [WIDTH-1:0] SEED      = 16'hACE1,
    parameter int unsigned      OUT_W     = 4,
    parameter int unsigned      MAX_VALUE = 9,
    parameter int unsigned      MAX_TRIES = 4
) (
    input  logic             i_Clk,
    input  logic             i_Reset_n,
    input  logic             i_Req,
    input  logic             i_Seed_Load,
    input  logic [WIDTH-1:0] i_Seed,
    output logic [OUT_W-1:0] o_Random_Num,
    output logic             o_Valid,
    output logic             o_Busy
);

    localparam logic [OUT_W-1:0] MAX_V    = OUT_W'(MAX_VALUE);
    // Wraps to zero when MAX_VALUE is all ones, but then nothing is ever folded.
    localparam logic [OUT_W-1:0] MAX_P1   = OUT_W'(MAX_VALUE + 1);
    localparam logic [3:0]       LAST_TRY = 4'(MAX_TRIES - 1);

    typedef enum logic [0:0] {StIdle, StDraw} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [3:0]       tries_q, tries_d;
    logic [OUT_W-1:0] num_q, num_d;
    logic             valid_q, valid_d;

    logic [OUT_W-1:0] cand;
    logic [OUT_W-1:0] folded;
    logic [OUT_W-1:0] deliver_val;
    logic             in_range;
    logic             accept;
    logic             final_try;

`ifdef LFSR_RANDOMIZER_NO_REPEAT_EN
    logic [OUT_W-1:0] last_q;
`endif

    // LFSR: seed load has priority, then lockup recovery, then a Galois step.
    always_comb begin
        lfsr_d = lfsr_q;
        if (i_Seed_Load) begin
            lfsr_d = (i_Seed == '0) ? SEED : i_Seed;
        end else if (lfsr_q == '0) begin
            lfsr_d = SEED;
        end else begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
        end
    end

    // Candidate evaluation uses the pre-step LFSR value.
    always_comb begin
        cand      = lfsr_q[OUT_W-1:0];
        in_range  = (cand <= MAX_V);
        folded    = in_range ? cand : OUT_W'(cand - MAX_P1);
        final_try = (tries_q == LAST_TRY);
`ifdef LFSR_RANDOMIZER_NO_REPEAT_EN
        accept = in_range && (cand != last_q);
        // Only reachable on the final try: bump a repeated value to its successor.
        if (folded != last_q) begin
            deliver_val = folded;
        end else if (last_q == MAX_V) begin
            deliver_val = '0;
        end else begin
            deliver_val = OUT_W'(last_q + 1'b1);
        end
`else
        accept      = in_range;
        deliver_val = folded;
`endif
    end

    always_comb begin
        state_d = state_q;
        tries_d = tries_q;
        num_d   = num_q;
        valid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A seed load in the same cycle drops the request.
                if (i_Req && !i_Seed_Load) begin
                    state_d = StDraw;
                    tries_d = '0;
                end
            end
            StDraw: begin
                if (i_Seed_Load) begin
                    state_d = StIdle;
                end else begin
                    tries_d = tries_q + 4'd1;
                    if (accept || final_try) begin
                        num_d   = deliver_val;
                        valid_d = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q <= StIdle;
            lfsr_q  <= SEED;
            tries_q <= '0;
            num_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            tries_q <= tries_d;
            num_q   <= num_d;
            valid_q <= valid_d;
        end
    end

`ifdef LFSR_RANDOMIZER_NO_REPEAT_EN
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            last_q <= '0;
        end else if (valid_d) begin
            last_q <= num_d;
        end
    end
`endif

    assign o_Random_Num = num_q;
    assign o_Valid      = valid_q;
    assign o_Busy       = (state_q == StDraw);

endmodule

// File: tb/tb_lfsr_randomizer.sv
module tb_lfsr_randomizer;

    localparam int SEED_I    = 32'hACE1;
    localparam int TAPS_I    = 32'hB400;
    localparam int MAX_VALUE = 9;
    localparam int MAX_TRIES = 4;
    localparam int RANGE     = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        seed_load = 1'b0;
    logic [15:0] seed = 16'd0;
    logic [3:0]  num, num1;
    logic        valid, valid1, busy, busy1;

    int n_pass = 0;
    int n_total = 0;
    int m_lfsr = SEED_I;
    int m_last = 0;

    always #5 clk = ~clk;

    lfsr_randomizer dut (
        .i_Clk(clk), .i_Reset_n(rst_n), .i_Req(req), .i_Seed_Load(seed_load),
        .i_Seed(seed), .o_Random_Num(num), .o_Valid(valid), .o_Busy(busy)
    );

    lfsr_randomizer #(.MAX_TRIES(1)) dut1 (
        .i_Clk(clk), .i_Reset_n(rst_n), .i_Req(req), .i_Seed_Load(seed_load),
        .i_Seed(seed), .o_Random_Num(num1), .o_Valid(valid1), .o_Busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int step(input int x);
        if (x == 0) return SEED_I;
        return (x % 2 == 1) ? ((x / 2) ^ TAPS_I) : (x / 2);
    endfunction

    // Walks the candidate sequence of one draw and returns what it delivers and when.
    function automatic void predict(input int l1, input int last, output int val,
                                    output int lat);
        int l;
        int c;
        l = l1;
        val = 0;
        lat = 0;
        for (int t = 1; t <= MAX_TRIES; t++) begin
            c = l % RANGE;
            if (t == MAX_TRIES) begin
                val = (c <= MAX_VALUE) ? c : c - (MAX_VALUE + 1);
`ifdef LFSR_RANDOMIZER_NO_REPEAT_EN
                if (val == last) val = (last == MAX_VALUE) ? 0 : last + 1;
`endif
                lat = t;
                return;
            end
`ifdef LFSR_RANDOMIZER_NO_REPEAT_EN
            if (c <= MAX_VALUE && c != last) begin
`else
            if (c <= MAX_VALUE) begin
`endif
                val = c;
                lat = t;
                return;
            end
            l = step(l);
        end
    endfunction

    // One clock edge; the model LFSR follows the inputs presented to that edge.
    task automatic tick();
        int nxt;
        if (seed_load) nxt = (seed == 16'd0) ? SEED_I : int'(seed);
        else nxt = step(m_lfsr);
        @(posedge clk);
        #1;
        m_lfsr = nxt;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req = 1'b0;
        seed_load = 1'b0;
        #1;
        check("rst_num", 32'(num), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_lfsr", 32'(dut.lfsr_q), SEED_I);
        @(negedge clk);
        rst_n = 1'b1;
        m_lfsr = SEED_I;
        m_last = 0;
    endtask

    task automatic draw(input int abort_at);
        int val, lat;
        req = 1'b1;
        tick();
        req = 1'b0;
        predict(m_lfsr, m_last, val, lat);
        for (int i = 1; i <= lat; i++) begin
            check("draw_busy", 32'(busy), 1);
            check("draw_valid_early", 32'(valid), 0);
            if (i == abort_at) begin
                seed_load = 1'b1;
                seed = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
                tick();
                seed_load = 1'b0;
                check("abort_busy", 32'(busy), 0);
                check("abort_valid", 32'(valid), 0);
                check("abort_num", 32'(num), 32'(m_last));
                check("abort_lfsr", 32'(dut.lfsr_q), 32'(m_lfsr));
                return;
            end
            tick();
        end
        check("draw_valid", 32'(valid), 1);
        check("draw_num", 32'(num), 32'(val));
        check("draw_busy_end", 32'(busy), 0);
        m_last = val;
        tick();
        check("valid_pulse", 32'(valid), 0);
        check("num_hold", 32'(num), 32'(val));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int val, lat;
        bit hit;

        do_reset();

        // Request at the first edge: candidate 0x0 from 0xE270.
        req = 1'b1;
        tick();
        req = 1'b0;
        check("e1_busy", 32'(busy), 1);
        check("e1_valid", 32'(valid), 0);
        tick();
`ifdef LFSR_RANDOMIZER_NO_REPEAT_EN
        check("e2_valid", 32'(valid), 0);
        check("e2_busy", 32'(busy), 1);
        tick();
        check("e3_valid", 32'(valid), 1);
        check("e3_num", 32'(num), 8);
`else
        check("e2_valid", 32'(valid), 1);
        check("e2_num", 32'(num), 0);
        check("e2_busy", 32'(busy), 0);
`endif

        // Request first sampled at edge 3: 12, 14 rejected, 7 delivered.
        do_reset();
        tick();
        tick();
        req = 1'b1;
        tick();
        req = 1'b0;
        check("e3_busy", 32'(busy), 1);
        check("e3_busy1", 32'(busy1), 1);
        tick();
        check("e4_busy", 32'(busy), 1);
        check("e4_valid", 32'(valid), 0);
        check("fold_valid1", 32'(valid1), 1);
        check("fold_num1", 32'(num1), 2);
        tick();
        check("e5_busy", 32'(busy), 1);
        check("e5_valid", 32'(valid), 0);
        tick();
        check("e6_valid", 32'(valid), 1);
        check("e6_num", 32'(num), 7);
        check("e6_busy", 32'(busy), 0);
        tick();
        check("e7_valid", 32'(valid), 0);
        check("e7_num", 32'(num), 7);
        m_last = 7;

        // Seed load during a draw aborts it.
        req = 1'b1;
        tick();
        req = 1'b0;
        check("abort_pre_busy", 32'(busy), 1);
        seed = 16'h1234;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        check("abort_d_busy", 32'(busy), 0);
        check("abort_d_valid", 32'(valid), 0);
        check("abort_d_num", 32'(num), 7);
        check("abort_d_lfsr", 32'(dut.lfsr_q), 32'h1234);

        // Seed load of zero together with a request: fallback seed, request dropped.
        seed = 16'd0;
        seed_load = 1'b1;
        req = 1'b1;
        tick();
        seed_load = 1'b0;
        req = 1'b0;
        check("zero_seed_lfsr", 32'(dut.lfsr_q), SEED_I);
        check("drop_busy", 32'(busy), 0);
        tick();
        check("drop_busy2", 32'(busy), 0);
        check("drop_valid", 32'(valid), 0);

        // Seed 0x0020, request next edge: candidate 0 then 8.
        do_reset();
        seed = 16'h0020;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        check("seed20_lfsr", 32'(dut.lfsr_q), 32'h0020);
        req = 1'b1;
        tick();
        req = 1'b0;
        check("seed20_busy", 32'(busy), 1);
        tick();
`ifdef LFSR_RANDOMIZER_NO_REPEAT_EN
        check("seed20_reject", 32'(valid), 0);
        tick();
        check("seed20_valid", 32'(valid), 1);
        check("seed20_num", 32'(num), 8);
        m_last = 8;
`else
        check("seed20_valid", 32'(valid), 1);
        check("seed20_num", 32'(num), 0);
        m_last = 0;
`endif
        tick();

        // Randomised draws with occasional reseeds and aborts.
        for (int n = 0; n < 80; n++) begin
            repeat ($urandom_range(0, 3)) tick();
            if ($urandom_range(0, 3) == 0) begin
                seed = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
                seed_load = 1'b1;
                tick();
                seed_load = 1'b0;
                check("rand_seed_lfsr", 32'(dut.lfsr_q), 32'(m_lfsr));
            end
            draw(($urandom_range(0, 4) == 0) ? int'($urandom_range(1, MAX_TRIES)) : 0);
        end

        // Asynchronous reset in the middle of a multi-cycle draw.
        hit = 1'b0;
        for (int n = 0; n < 40 && !hit; n++) begin
            req = 1'b1;
            tick();
            req = 1'b0;
            predict(m_lfsr, m_last, val, lat);
            if (lat >= 2) begin
                #2;
                rst_n = 1'b0;
                #1;
                check("async_num", 32'(num), 0);
                check("async_valid", 32'(valid), 0);
                check("async_busy", 32'(busy), 0);
                check("async_lfsr", 32'(dut.lfsr_q), SEED_I);
                hit = 1'b1;
            end else begin
                tick();
                check("pre_async_num", 32'(num), 32'(val));
                m_last = val;
                tick();
            end
        end
        check("async_reached", 32'(hit), 1);

        @(negedge clk);
        rst_n = 1'b1;
        m_lfsr = SEED_I;
        m_last = 0;
        draw(0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lfsr_randomizer.md
LFSR_RANDOMIZER -- requirements
Module: lfsr_randomizer

Interface
REQ-001 Parameter WIDTH, default 16, LFSR width; legal range 3..32.
REQ-002 Parameter TAPS, default 16'hB400, Galois feedback mask, WIDTH bits.
REQ-003 Parameter SEED, default 16'hACE1, reset and fallback LFSR value; SHALL be nonzero.
REQ-004 Parameter OUT_W, default 4, output width; OUT_W <= WIDTH.
REQ-005 Parameter MAX_VALUE, default 9, largest deliverable value; 2**(OUT_W-1)-1 <= MAX_VALUE <= 2**OUT_W-1.
REQ-006 Parameter MAX_TRIES, default 4, draw attempts before fold; legal range 1..15.
REQ-007 i_Clk  in  1  sole clock, all state on rising edge.
REQ-008 i_Reset_n  in  1  asynchronous, active-low reset.
REQ-009 i_Req  in  1  request one number; sampled in IDLE only.
REQ-010 i_Seed_Load  in  1  load i_Seed into LFSR.
REQ-011 i_Seed  in  WIDTH  seed value.
REQ-012 o_Random_Num  out  OUT_W  last delivered number, held until next delivery.
REQ-013 o_Valid  out  1  one-cycle pulse, o_Random_Num updated.
REQ-014 o_Busy  out  1  high while state is DRAW.

Function
REQ-015 LFSR SHALL step every edge not loading a seed: next = (lfsr >> 1) ^ (lfsr[0] ? TAPS : 0). Free-running in all states.
REQ-016 States: IDLE, DRAW. IDLE + i_Req -> DRAW, try counter cleared. i_Req ignored in DRAW.
REQ-017 In DRAW, each edge evaluates candidate = current (pre-step) lfsr[OUT_W-1:0] and increments the try counter.
REQ-018 Candidate <= MAX_VALUE: latch into o_Random_Num, o_Valid = 1 next cycle, -> IDLE.
REQ-019 Candidate > MAX_VALUE on tries 1..MAX_TRIES-1: reject, stay in DRAW.
REQ-020 Candidate > MAX_VALUE on try MAX_TRIES: deliver candidate-(MAX_VALUE+1) (always in range), -> IDLE.
REQ-021 Latency: req sampled at edge k; o_Valid high after edge k+1 minimum, after edge k+MAX_TRIES maximum.
REQ-022 i_Seed_Load SHALL load i_Seed, or SEED if i_Seed == 0, into the LFSR instead of stepping.
REQ-023 i_Seed_Load in DRAW aborts the draw: -> IDLE, no o_Valid, o_Random_Num unchanged.
REQ-024 i_Seed_Load and i_Req together in IDLE: seed load wins, request dropped.
REQ-025 LFSR == 0 (lockup) SHALL reload SEED at the next edge.

Reset
REQ-026 On i_Reset_n low, immediately: lfsr = SEED, state IDLE, try counter 0, o_Random_Num 0, o_Valid 0, o_Busy 0, last-value register 0.
REQ-027 Reset mid-draw discards the draw. First edge after deassertion behaves as IDLE.

Configuration
REQ-028 Macro LFSR_RANDOMIZER_NO_REPEAT_EN defined: an in-range candidate equal to the last delivered value counts as a reject. On the final try, the value delivered is last+1, wrapping past MAX_VALUE to 0, if the folded or accepted value equals last.
REQ-029 Macro undefined: repeats allowed, and the last-value register is not instantiated.

Verification
REQ-030 Defaults, i_Req high for edge 1 after reset -> o_Random_Num = 0, o_Valid pulse after edge 2.
REQ-031 i_Req first sampled at edge 3 after reset -> candidates 12 and 14 rejected, 7 delivered after edge 6, o_Busy high for 3 cycles.
REQ-032 MAX_TRIES = 1, i_Req at edge 3 -> candidate 12 folded, o_Random_Num = 2 after edge 4.
REQ-033 i_Seed_Load with i_Seed = 0 -> LFSR = 16'hACE1. i_Seed_Load during DRAW -> IDLE, no o_Valid.
REQ-034 With macro, last = 0, load seed 16'h0020, i_Req next edge -> candidate 0 rejected, 8 delivered. Without macro -> 0 delivered.
REQ-035 Reset asserted mid-DRAW -> all outputs 0 asynchronously, LFSR = 16'hACE1.
